// File: rtl/frame_sequencer_if.sv
// Avalon-MM write-only link between the frame sequencer and the sprite
// peripheral's register file.
interface frame_sequencer_if;
  logic [2:0]  av_address;
  logic [15:0] av_writedata;
  logic        av_write;
  logic        av_waitrequest;

  modport master (
    output av_address,
    output av_writedata,
    output av_write,
    input  av_waitrequest
  );

  modport slave (
    input  av_address,
    input  av_writedata,
    input  av_write,
    output av_waitrequest
  );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame player physics step followed by an Avalon-MM register update
// sequence (y, x_shift, flags) into the sprite display peripheral.
module frame_sequencer #(
  parameter int GROUND_Y    = 400,
  parameter int GRAVITY     = 1,
  parameter int JUMP_VEL    = 12,
  parameter int MAX_FALL    = 15,
  parameter int SCROLL_STEP = 2,
  parameter int X_WRAP      = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                start,
  input  logic                stop,
  input  logic                jump,
  frame_sequencer_if.master   av,
  output logic                busy,
  output logic                overrun,
  output logic [15:0]         frame_count
);

  typedef enum logic [2:0] {IDLE, PHYSICS, WR_Y, WR_X, WR_FLAGS, DONE} state_t;

  localparam logic signed [10:0] GROUND_T = 11'(GROUND_Y);
  localparam logic        [16:0] X_MASK   = 17'(X_WRAP - 1);

  state_t             state;
  logic               running;
  logic               on_ground;
  logic               jump_prev;
  logic               jump_pending;
  logic        [9:0]  y;
  logic signed [7:0]  vel;
  logic        [15:0] x_shift;

  logic signed [7:0]  vel_j;
  logic               og_j;
  logic signed [10:0] t;
  logic signed [8:0]  vel_g;
  logic        [9:0]  y_nx;
  logic signed [7:0]  vel_nx;
  logic               og_nx;
  logic        [16:0] x_sum;
  logic        [15:0] x_nx;

  always_comb begin
    vel_j = vel;
    og_j  = on_ground;
    if (on_ground && jump_pending) begin
      vel_j = 8'(-JUMP_VEL);
      og_j  = 1'b0;
    end
    t      = $signed({1'b0, y}) + 11'(vel_j);
    vel_g  = 9'(vel_j) + 9'(GRAVITY);
    y_nx   = y;
    vel_nx = vel_j;
    og_nx  = og_j;
    if (t >= GROUND_T) begin
      y_nx   = 10'(GROUND_Y);
      vel_nx = '0;
      og_nx  = 1'b1;
    end else if (t < 11'sd0) begin
      y_nx   = '0;
      vel_nx = '0;
    end else begin
      y_nx   = t[9:0];
      vel_nx = (vel_g > 9'(MAX_FALL)) ? 8'(MAX_FALL) : vel_g[7:0];
    end
    x_sum = {1'b0, x_shift} + 17'(SCROLL_STEP);
    x_nx  = 16'(x_sum & X_MASK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      av.av_write     <= 1'b0;
      av.av_address   <= '0;
      av.av_writedata <= '0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      frame_count     <= '0;
      running         <= 1'b0;
      y               <= 10'(GROUND_Y);
      vel             <= '0;
      on_ground       <= 1'b1;
      x_shift         <= '0;
      jump_prev       <= 1'b0;
      jump_pending    <= 1'b0;
    end else begin
      jump_prev <= jump;
      if (frame_start && state != IDLE) overrun <= 1'b1;

      // Clear-then-set: an edge arriving during PHYSICS is kept for next frame.
      if (state == PHYSICS) jump_pending <= 1'b0;
      if (jump && !jump_prev) jump_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            running   <= 1'b1;
            y         <= 10'(GROUND_Y);
            vel       <= '0;
            on_ground <= 1'b1;
            x_shift   <= '0;
          end else if (stop) begin
            running <= 1'b0;
          end
          if (frame_start) begin
            busy <= 1'b1;
            if (running) begin
              state <= PHYSICS;
            end else begin
              state           <= WR_FLAGS;
              av.av_write     <= 1'b1;
              av.av_address   <= 3'd6;
              av.av_writedata <= {14'b0, on_ground, running};
            end
          end
        end
        PHYSICS: begin
          y               <= y_nx;
          vel             <= vel_nx;
          on_ground       <= og_nx;
          x_shift         <= x_nx;
          av.av_write     <= 1'b1;
          av.av_address   <= 3'd0;
          av.av_writedata <= {6'b0, y_nx};
          state           <= WR_Y;
        end
        WR_Y: begin
          if (!av.av_waitrequest) begin
            av.av_address   <= 3'd1;
            av.av_writedata <= x_shift;
            state           <= WR_X;
          end
        end
        WR_X: begin
          if (!av.av_waitrequest) begin
            av.av_address   <= 3'd6;
            av.av_writedata <= {14'b0, on_ground, running};
            state           <= WR_FLAGS;
          end
        end
        WR_FLAGS: begin
          if (!av.av_waitrequest) begin
            av.av_write <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          frame_count <= frame_count + 16'd1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          av.av_write <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame game-state controller for the player sprite display peripheral.
- On each frame-start pulse it runs one physics step: jump, gravity, ground clamp and horizontal scroll.
- It then pushes the results into the peripheral's register file through an Avalon-MM write master.
- It sits between the vsync edge detector and the peripheral's Avalon slave port, replacing software register writes for the per-frame fields.

Parameters:
- GROUND_Y, 400, player top-row y when resting on ground (pixels).
- GRAVITY, 1, velocity increment per frame (pixels/frame).
- JUMP_VEL, 12, upward launch speed magnitude (pixels/frame).
- MAX_FALL, 15, maximum downward velocity.
- SCROLL_STEP, 2, x_shift increment per running frame.
- X_WRAP, 4096, x_shift modulus; must be a power of two, at most 65536.

Ports:
- clk, in, 1, system clock (50 MHz).
- reset_n, in, 1, asynchronous active-low reset.
- frame_start, in, 1, single-cycle pulse at start of vertical blank.
- start, in, 1, pulse: begin run.
- stop, in, 1, pulse: end run.
- jump, in, 1, level from button, synchronous to clk.
- av_address, out, 3, peripheral register index.
- av_writedata, out, 16, write data.
- av_write, out, 1, write strobe.
- av_waitrequest, in, 1, slave stall.
- busy, out, 1, sequence in progress (state != IDLE).
- overrun, out, 1, sticky: frame_start arrived while busy.
- frame_count, out, 16, number of completed sequences, wraps at 65536.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, av_write=0, av_address=0, av_writedata=0
  - busy=0, overrun=0, frame_count=0
  - running=0, y=GROUND_Y, vel=0, on_ground=1, x_shift=0, jump_pending=0
- Internal widths:
  - y: 10-bit unsigned.
  - vel: 8-bit signed; positive means downward.
  - x_shift: 16-bit; x_shift_next=(x_shift+SCROLL_STEP) mod X_WRAP.
- jump_pending is set on a 0->1 edge of jump (registered previous value) and cleared in PHYSICS whether consumed or not.
- start sets running=1 and loads y=GROUND_Y, vel=0, on_ground=1, x_shift=0.
- stop clears running.
- If start and stop are asserted in the same cycle, start wins.
- start and stop are honoured only in IDLE; in any other state they are ignored.
- States:
  - IDLE: on frame_start, go to PHYSICS if running, else go to WR_FLAGS.
  - PHYSICS (1 cycle):
    1. If on_ground and jump_pending: vel=-JUMP_VEL, on_ground=0.
    2. Compute t=y+vel in 11-bit signed.
    3. If t>=GROUND_Y: y=GROUND_Y, vel=0, on_ground=1.
    4. Else if t<0: y=0, vel=0.
    5. Else: y=t, vel=min(vel+GRAVITY, MAX_FALL).
    6. x_shift=x_shift_next.
    7. Go to WR_Y.
  - WR_Y: address 0, data {6'b0,y}.
  - WR_X: address 1, data x_shift.
  - WR_FLAGS: address 6, data {14'b0,on_ground,running}.
  - DONE (1 cycle): frame_count+=1, go to IDLE.
- Write sequence when running: WR_Y -> WR_X -> WR_FLAGS -> DONE.
- Avalon write rules:
  - In each WR_* state, av_write=1 and address/data are driven from registers.
  - Address and data are held stable while av_waitrequest=1.
  - The transfer completes on the first cycle with av_write=1 and av_waitrequest=0; the FSM advances on that edge.
  - av_write=0 in IDLE, PHYSICS and DONE.
  - No back-to-back strobe merging: each WR_* state is at least 1 cycle.
- Latency with no wait states:
  - frame_start at cycle N -> PHYSICS at N+1; WR_Y at N+2, WR_X at N+3, WR_FLAGS at N+4; DONE at N+5; IDLE at N+6.
  - Not running: WR_FLAGS at N+1, DONE at N+2.
- frame_start while state != IDLE sets overrun=1. The pulse is dropped, not queued. overrun is cleared only by reset.
- frame_start in the same cycle the FSM enters IDLE from DONE is accepted; it is not an overrun.
- Reset mid-write drops av_write immediately; the peripheral may hold a partial update.

Test Plan:
- Reset, start, then 3 frame_start pulses, no jump, waitrequest=0:
  - Writes per frame are (0,400), (1,2/4/6), (6,0x0003).
  - frame_count=3.
  - Each av_write is high for exactly 1 cycle.
- Jump edge before frame 1, on ground:
  - y sequence over frames 1..4 is 388, 377, 367, 358 (vel -12, -11, -10, -9).
  - Flags written 0x0001 while airborne.
  - Player lands at exactly y=400 with vel=0 and flags=0x0003.
- av_waitrequest held high 5 cycles during WR_X:
  - av_address=1 and av_writedata are stable for all 6 cycles.
  - The next write (address 6) appears only after waitrequest falls.
- frame_start pulsed while in WR_X -> overrun=1, no second sequence starts, frame_count increments once; overrun stays 1 until reset_n asserted.
- x_shift at 4094 with SCROLL_STEP=2, X_WRAP=4096 -> next written x_shift=0.
- stop in IDLE then frame_start -> single write (6,0x0002 if on_ground else 0x0000), no y/x writes.
- stop asserted while busy -> ignored.
